// File: rtl/pipe_io_ctrl_if.sv
// pipe_io_ctrl_if: MEM-stage load/store bus between the pipeline and the
// memory-mapped I/O controller.
//   addr   byte address from the MEM stage (bits [1:0] ignored by the device)
//   wdata  store data
//   we     store strobe
//   re     load strobe
//   hit    device claims the address (combinational)
//   rdata  registered read data
//   rvalid one-cycle pulse the cycle after an accepted read
interface pipe_io_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
    logic              hit;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output addr, wdata, we, re,
        input  hit, rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output hit, rdata, rvalid
    );
endinterface

// File: rtl/pipe_io_ctrl.sv
// pipe_io_ctrl: memory-mapped I/O controller for the MEM stage.
// Maps NUM_OUT output registers, NUM_IN synchronised input ports, a sticky
// change STATUS (write-1-to-clear), MASK and CTRL (IRQ_EN) into a 256-byte
// window at IO_BASE. Reads return one cycle after the request.
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   bus        load/store bus (slave side)
//   in_ports   asynchronous inputs, port j = [j*DATA_W +: DATA_W]
//   out_ports  output registers, packed the same way
//   irq        registered interrupt request
module pipe_io_ctrl #(
    parameter int                 DATA_W  = 32,
    parameter int                 NUM_OUT = 3,
    parameter int                 NUM_IN  = 2,
    parameter logic [31:0]        IO_BASE = 32'hFFFF_FF00,
    parameter logic [DATA_W-1:0]  OUT_RST = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    pipe_io_ctrl_if.slave               bus,
    input  logic [NUM_IN*DATA_W-1:0]    in_ports,
    output logic [NUM_OUT*DATA_W-1:0]   out_ports,
    output logic                        irq
);

    // word offsets inside the window
    localparam logic [5:0] OFF_IN     = 6'h10;
    localparam logic [5:0] OFF_STATUS = 6'h20;
    localparam logic [5:0] OFF_MASK   = 6'h21;
    localparam logic [5:0] OFF_CTRL   = 6'h22;

    logic [5:0]               off;
    logic                     wr;
    logic                     rd;
    logic [NUM_IN*DATA_W-1:0] sync1;
    logic [NUM_IN*DATA_W-1:0] sync2;
    logic [NUM_IN*DATA_W-1:0] prev;
    logic [NUM_IN-1:0]        change;
    logic [NUM_IN-1:0]        status;
    logic [NUM_IN-1:0]        status_nxt;
    logic [NUM_IN-1:0]        mask;
    logic                     irq_en;
    logic [DATA_W-1:0]        rd_mux;
    logic                     addr_unused;

    assign addr_unused = ^bus.addr[1:0];

    assign off     = bus.addr[7:2];
    assign bus.hit = (bus.addr[31:8] == IO_BASE[31:8]);
    assign wr      = bus.we & bus.hit;
    assign rd      = bus.re & bus.hit;

    always_comb begin
        change = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            change[j] = (sync2[j*DATA_W +: DATA_W] != prev[j*DATA_W +: DATA_W]);
        end
    end

    // A fresh change wins over a same-cycle W1C of that bit.
    always_comb begin
        status_nxt = change | status;
        if (wr && (off == OFF_STATUS)) begin
            status_nxt = change | (status & ~bus.wdata[NUM_IN-1:0]);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (off == 6'(i)) begin
                rd_mux = out_ports[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (off == (OFF_IN + 6'(j))) begin
                rd_mux = sync2[j*DATA_W +: DATA_W];
            end
        end
        if (off == OFF_STATUS) begin
            for (int j = 0; j < NUM_IN; j++) begin
                rd_mux[j] = status[j];
            end
        end
        if (off == OFF_MASK) begin
            for (int j = 0; j < NUM_IN; j++) begin
                rd_mux[j] = mask[j];
            end
        end
        if (off == OFF_CTRL) begin
            rd_mux[0] = irq_en;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_ports  <= {NUM_OUT{OUT_RST}};
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            status     <= '0;
            mask       <= '0;
            irq_en     <= 1'b0;
            irq        <= 1'b0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            sync1  <= in_ports;
            sync2  <= sync1;
            prev   <= sync2;
            status <= status_nxt;
            irq    <= irq_en & (|(status_nxt & mask));

            bus.rvalid <= rd;
            if (rd) begin
                bus.rdata <= rd_mux;
            end

            if (wr) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (off == 6'(i)) begin
                        out_ports[i*DATA_W +: DATA_W] <= bus.wdata;
                    end
                end
                if (off == OFF_MASK) begin
                    mask <= bus.wdata[NUM_IN-1:0];
                end
                if (off == OFF_CTRL) begin
                    irq_en <= bus.wdata[0];
                end
            end
        end
    end

endmodule

// File: doc/pipe_io_ctrl.md
# pipe_io_ctrl

Parametrised memory-mapped I/O controller for the MEM stage of the pipelined CPU. It maps NUM_OUT output registers and NUM_IN input ports into a 256-byte window at IO_BASE. It adds three things the fixed three-output/two-input arrangement lacked:
- two-flop input synchronisation;
- sticky per-input change detection with write-1-to-clear status;
- a maskable interrupt request.

Reads return one cycle after the request, which fits the registered MEM/WB boundary.

## Interface
- DATA_W, 32: data width of every port and register.
- NUM_OUT, 3: output registers, 1..16.
- NUM_IN, 2: input ports, 1..16, and at most DATA_W.
- IO_BASE, 32'hFFFF_FF00: window base address; bits [7:0] must be zero.
- OUT_RST, 0: reset value of every output register.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the MEM stage (malu); bits [1:0] are ignored.
- wdata  in  DATA_W  store data (mb).
- we  in  1  store strobe (mwmem).
- re  in  1  load strobe.
- hit  out  1  combinational; 1 when addr[31:8] == IO_BASE[31:8].
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  registered; 1 for exactly the cycle after an accepted read.
- in_ports  in  NUM_IN*DATA_W  asynchronous inputs; port j is bits [j*DATA_W +: DATA_W].
- out_ports  out  NUM_OUT*DATA_W  output registers, packed the same way.
- irq  out  1  registered interrupt request.

## Operation
Word offset is off = addr[7:2]. The register map is:
- 0x00 + 4i, i < NUM_OUT: OUT[i], read/write.
- 0x40 + 4j, j < NUM_IN: IN[j], read-only; returns the synchronised value (the second sync flop).
- 0x80 STATUS: bit j set = input j changed since last cleared.
  - Read returns the bits.
  - Write clears every bit whose wdata bit is 1.
  - Bits at NUM_IN and above read 0.
- 0x84 MASK: bits [NUM_IN-1:0] read/write; other bits read 0.
- 0x88 CTRL: bit0 = IRQ_EN, read/write; other bits read 0.
- Any other offset in the window: read returns 0, write is ignored.

Access rules:
- A write takes effect only when we=1 and hit=1.
- Writes to IN[j] are ignored.
- A read is accepted when re=1 and hit=1.
- If re=0 or hit=0, rdata holds its previous value and rvalid=0.
- If we and re are both 1 at the same offset, the read returns the old value and the write lands at the same edge.

Input synchronisation and change detection:
- Each input passes through sync1 then sync2, then a prev register that holds the previous sync2 value.
- change[j] = (sync2[j] != prev[j]), compared over the full word.
- STATUS[j] next value = change[j] OR (STATUS[j] AND NOT (W1C write AND wdata[j])). A new change therefore wins over a same-cycle clear.

Interrupt:
- irq next value = IRQ_EN AND |(STATUS next value & MASK).

Reset sets:
- OUT = OUT_RST;
- sync1, sync2 and prev = 0;
- STATUS, MASK, CTRL = 0;
- rdata = 0, rvalid = 0, irq = 0.

The first two post-reset cycles must not flag a change when the inputs are 0. Nonzero inputs may set STATUS once the synchronised value arrives; this is the defined behaviour.

## Timing
- Write: out_ports update at the edge where we=1; they are visible in the next cycle.
- Read: request in cycle N gives rdata/rvalid in cycle N+1. This is back-to-back capable, one read per cycle.
- Input path:
  - in_ports change before edge E.
  - sync2 shows the new value after E+1, so IN[j] reads reflect it from cycle E+2.
  - STATUS[j] sets at E+2.
  - irq rises at E+2, the same edge as STATUS.
- W1C: STATUS clears at the write edge; irq falls at the same edge if no other masked bit remains set.
- Reset asserted mid-access: the pending rvalid is dropped in the next cycle and all state returns to reset values.

## Test plan
1. Reset, then check defaults: out_ports all 0, rdata=0, rvalid=0, irq=0. Read 0x88 -> 0.
2. Write 0xDEADBEEF to IO_BASE+0x04 -> out_ports[63:32]=0xDEADBEEF the next cycle. Read it back -> rdata=0xDEADBEEF with rvalid=1 exactly one cycle after re.
3. Set MASK=0x1 and CTRL=0x1, then change in_port0 from 0 to 0x5 at edge E -> IN[0] reads 0x5 from E+2; STATUS=0x1 and irq=1 at E+2.
4. Write 0x1 to STATUS in the same cycle as a new in_port0 change is detected -> STATUS bit stays 1 and irq stays 1. Write 0x1 again with no change -> STATUS=0 and irq=0.
5. Write 0x1234 to IN[1] (IO_BASE+0x44) and to IO_BASE+0x90 -> no state change. Then read 0x90 -> rdata=0.
6. Write 0x1 to addr 0x0000_1004, outside the window -> hit=0 and out_ports unchanged. Assert reset while rvalid is pending -> rvalid=0 the next cycle and all registers return to reset values.
